rescale_sched: RTL and testbench

- Shares one 3-stage requantization pipeline (multiply by scale, add 0.5 LSB, right shift, narrow) between NUM_REQ conv accumulator channels.
- Round-robin arbitration over valid/ready requesters.
- Per-channel scale register file, written through a config port.
- Output stream carries the 8-bit activation plus the source channel tag; sits between the conv accumulators and the activation buffer.

---
 rtl/rescale_pkg.sv | 28 ++
 rtl/rescale_pipe.sv | 80 ++++++++
 rtl/rescale_sched.sv | 114 +++++++++++
 tb/tb_rescale_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rescale_pkg.sv
// Shared constants and types for the rescale scheduler.
// Optional saturation of the narrowed result is enabled by defining RESCALE_SAT_EN.
package rescale_pkg;

    localparam int NUM_REQ_D        = 4;
    localparam int BITWIDTH_IN_D    = 24;
    localparam int BITWIDTH_OUT_D   = 8;
    localparam int BITWIDTH_SCALE_D = 8;
    localparam int RIGHT_SHIFT_D    = 16;
    localparam int SCALE_RST_D      = 181;

    localparam int TAG_W  = $clog2(NUM_REQ_D);
    localparam int PROD_W = BITWIDTH_IN_D + BITWIDTH_SCALE_D;
    localparam int SUM_W  = PROD_W + 1;

    localparam logic [SUM_W-1:0] ROUND_CONST = SUM_W'(1) << (RIGHT_SHIFT_D - 1);

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [PROD_W-1:0] prod_t;

    // One extra data bit so the rounding add in stage 2 never overflows.
    typedef struct packed {
        logic             valid;
        tag_t             tag;
        logic [SUM_W-1:0] data;
    } stage_t;

endpackage

// File: rtl/rescale_pipe.sv
// Three-stage requantization datapath: multiply, round, shift+narrow.
// Narrowing wraps by default; RESCALE_SAT_EN makes it clamp to the max code.
module rescale_pipe
    import rescale_pkg::*;
#(
    parameter int BITWIDTH_IN    = BITWIDTH_IN_D,
    parameter int BITWIDTH_SCALE = BITWIDTH_SCALE_D,
    parameter int BITWIDTH_OUT   = BITWIDTH_OUT_D,
    parameter int RIGHT_SHIFT    = RIGHT_SHIFT_D
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      adv,
    input  logic                      in_valid,
    input  tag_t                      in_tag,
    input  logic [BITWIDTH_IN-1:0]    in_data,
    input  logic [BITWIDTH_SCALE-1:0] in_scale,
    output logic                      out_valid,
    output tag_t                      out_tag,
    output logic [BITWIDTH_OUT-1:0]   out_data
);

    stage_t s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [SUM_W-1:0]        shifted;
    logic [BITWIDTH_OUT-1:0] narrowed;

    always_comb begin
        shifted = s2_q.data >> RIGHT_SHIFT;
`ifdef RESCALE_SAT_EN
        if (|shifted[SUM_W-1:BITWIDTH_OUT])
            narrowed = '1;
        else
            narrowed = shifted[BITWIDTH_OUT-1:0];
`else
        narrowed = shifted[BITWIDTH_OUT-1:0];
`endif
    end

    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        if (adv) begin
            s1_d.valid = in_valid;
            s1_d.tag   = in_tag;
            s1_d.data  = {1'b0, prod_t'(in_data) * prod_t'(in_scale)};
            s2_d.valid = s1_q.valid;
            s2_d.tag   = s1_q.tag;
            s2_d.data  = s1_q.data + ROUND_CONST;
            s3_d.valid = s2_q.valid;
            s3_d.tag   = s2_q.tag;
            s3_d.data  = {{(SUM_W-BITWIDTH_OUT){1'b0}}, narrowed};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign out_valid = s3_q.valid;
    assign out_tag   = s3_q.tag;
    assign out_data  = s3_q.data[BITWIDTH_OUT-1:0];

    // Stage-3 upper bits are always zero; the wrap build also ignores the high shifted bits.
    logic unused_bits;
`ifdef RESCALE_SAT_EN
    assign unused_bits = ^s3_q.data[SUM_W-1:BITWIDTH_OUT];
`else
    assign unused_bits = ^{s3_q.data[SUM_W-1:BITWIDTH_OUT], shifted[SUM_W-1:BITWIDTH_OUT]};
`endif

endmodule

// File: rtl/rescale_sched.sv
// Round-robin scheduler sharing one requantization pipeline across NUM_REQ channels.
// Holds the per-channel scale file; RESCALE_SAT_EN selects saturating narrowing in the pipe.
module rescale_sched
    import rescale_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_D,
    parameter int BITWIDTH_IN    = BITWIDTH_IN_D,
    parameter int BITWIDTH_OUT   = BITWIDTH_OUT_D,
    parameter int BITWIDTH_SCALE = BITWIDTH_SCALE_D,
    parameter int RIGHT_SHIFT    = RIGHT_SHIFT_D,
    parameter int SCALE_RST      = SCALE_RST_D
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*BITWIDTH_IN-1:0] req_data,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_REQ)-1:0]     cfg_idx,
    input  logic [BITWIDTH_SCALE-1:0]      cfg_scale,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BITWIDTH_OUT-1:0]        out_data,
    output logic [$clog2(NUM_REQ)-1:0]     out_tag
);

    logic [BITWIDTH_SCALE-1:0] scale_q [NUM_REQ];
    logic [BITWIDTH_SCALE-1:0] scale_d [NUM_REQ];
    tag_t                      last_grant_q, last_grant_d;
    tag_t                      grant_idx, idx;
    logic                      grant_vld, advance;
    logic [NUM_REQ-1:0]        grant_oh;
    logic [BITWIDTH_IN-1:0]    sel_data;
    logic [BITWIDTH_SCALE-1:0] sel_scale;
    tag_t                      pipe_tag;

    assign advance = !(out_valid && !out_ready);

    // Search starts one past the last accepted channel, so a just-served channel goes last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        idx       = '0;
        if (advance) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                idx = tag_t'((int'(last_grant_q) + off) % NUM_REQ);
                if (!grant_vld && req_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = idx;
                end
            end
        end
        if (grant_vld)
            grant_oh[grant_idx] = 1'b1;
    end

    assign req_ready = grant_oh & {NUM_REQ{rstn}};

    always_comb begin
        sel_data  = '0;
        sel_scale = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == tag_t'(i)) begin
                sel_data  = req_data[i*BITWIDTH_IN +: BITWIDTH_IN];
                sel_scale = scale_q[i];
            end
        end
    end

    // The grant reads scale_q, so a same-cycle write to that channel is seen only by later grants.
    always_comb begin
        scale_d      = scale_q;
        last_grant_d = grant_vld ? grant_idx : last_grant_q;
        if (cfg_we) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cfg_idx == tag_t'(i))
                    scale_d[i] = cfg_scale;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant_q <= tag_t'(NUM_REQ - 1);
            for (int i = 0; i < NUM_REQ; i++)
                scale_q[i] <= BITWIDTH_SCALE'(SCALE_RST);
        end else begin
            last_grant_q <= last_grant_d;
            scale_q      <= scale_d;
        end
    end

    rescale_pipe #(
        .BITWIDTH_IN    (BITWIDTH_IN),
        .BITWIDTH_SCALE (BITWIDTH_SCALE),
        .BITWIDTH_OUT   (BITWIDTH_OUT),
        .RIGHT_SHIFT    (RIGHT_SHIFT)
    ) u_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .adv       (advance),
        .in_valid  (grant_vld),
        .in_tag    (grant_idx),
        .in_data   (sel_data),
        .in_scale  (sel_scale),
        .out_valid (out_valid),
        .out_tag   (pipe_tag),
        .out_data  (out_data)
    );

    assign out_tag = pipe_tag;

endmodule

// File: tb/tb_rescale_sched.sv
// Self-checking bench for rescale_sched: directed scenarios plus a randomized run
// checked by a cycle-level reference model of arbitration, latency and rescaling.
module tb_rescale_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [95:0] req_data;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [7:0]  cfg_scale;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_tag;

    int total = 0;
    int bad   = 0;

    rescale_sched dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_scale (cfg_scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: round-half-up of data*scale/65536, then wrap or clamp to 8 bits.
    function automatic logic [7:0] rescale(input logic [23:0] d, input logic [7:0] s);
        longint v;
        v = (longint'(d) * longint'(s) + 64'd32768) >> 16;
`ifdef RESCALE_SAT_EN
        if (v > 255) v = 255;
`endif
        return v[7:0];
    endfunction

    // Model: three result slots ahead of the output, a round-robin pointer, a scale table.
    bit         mv [3];
    logic [1:0] mt [3];
    logic [7:0] md [3];
    int         m_last = 3;
    logic [7:0] m_scale [4];

    always @(negedge clk) begin
        logic [3:0] exp_rdy;
        bit         adv;
        int         g;
        int         c;
        if (!rstn) begin
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mon_reset_valid got=%b exp=0", out_valid);
            end
            for (int k = 0; k < 3; k++) mv[k] = 0;
            m_last = 3;
            for (int i = 0; i < 4; i++) m_scale[i] = 8'd181;
        end else begin
            total++;
            if (out_valid !== mv[2]) begin
                bad++;
                $display("FAIL mon_out_valid got=%b exp=%b t=%0t", out_valid, mv[2], $time);
            end
            if (mv[2]) begin
                total++;
                if (out_data !== md[2] || out_tag !== mt[2]) begin
                    bad++;
                    $display("FAIL mon_out_data got=%0d tag=%0d exp=%0d tag=%0d t=%0t",
                             out_data, out_tag, md[2], mt[2], $time);
                end
            end
            adv = !(mv[2] && !out_ready);
            exp_rdy = 4'b0;
            g = -1;
            if (adv) begin
                for (int off = 1; off <= 4; off++) begin
                    c = (m_last + off) % 4;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            total++;
            if (req_ready !== exp_rdy) begin
                bad++;
                $display("FAIL mon_req_ready got=%b exp=%b t=%0t", req_ready, exp_rdy, $time);
            end
            if (adv) begin
                mv[2] = mv[1]; mt[2] = mt[1]; md[2] = md[1];
                mv[1] = mv[0]; mt[1] = mt[0]; md[1] = md[0];
                mv[0] = (g >= 0);
                if (g >= 0) begin
                    mt[0]  = g[1:0];
                    md[0]  = rescale(req_data[g*24 +: 24], m_scale[g]);
                    m_last = g;
                end
            end
            if (cfg_we) m_scale[cfg_idx] = cfg_scale;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rstn = 1'b0; req_valid = 4'b0; cfg_we = 1'b0; out_ready = 1'b1;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic get_out(output logic [7:0] d, output logic [1:0] t, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(out_valid === 1'b1 && out_ready === 1'b1) && waited < 20);
        total++;
        if (!(out_valid === 1'b1 && out_ready === 1'b1)) begin
            bad++;
            $display("FAIL get_out_timeout got=%b exp=1 after %0d cycles", out_valid, waited);
        end
        d = out_data;
        t = out_tag;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 4'hF; req_data = '0; cfg_we = 1'b0;
        cfg_idx = '0; cfg_scale = '0; out_ready = 1'b1;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        total++; if (out_data !== 8'd0) begin bad++; $display("FAIL rst_out_data got=%0d exp=0", out_data); end
        total++; if (out_tag !== 2'd0) begin bad++; $display("FAIL rst_out_tag got=%0d exp=0", out_tag); end
        req_valid = 4'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_latency();
        step();
        req_valid = 4'b0001; req_data = '0; req_data[23:0] = 24'd1000;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL lat_grant got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (k < 3) begin
                if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early cycle=%0d got=%b exp=0", k, out_valid); end
            end else if (out_valid !== 1'b1 || out_data !== 8'd3 || out_tag !== 2'd0) begin
                bad++;
                $display("FAIL lat_result got=%b/%0d/%0d exp=1/3/0", out_valid, out_data, out_tag);
            end
        end
    endtask

    task automatic test_rounding();
        logic [7:0] d;
        logic [1:0] t;
        int w;
        step();
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_scale = 8'd1;
        step();
        cfg_we = 1'b0; req_valid = 4'b0001; req_data[23:0] = 24'h008000;
        step();
        req_data[23:0] = 24'h007FFF;
        step();
        req_valid = 4'b0;
        get_out(d, t, w);
        total++; if (d !== 8'd1 || t !== 2'd0) begin bad++; $display("FAIL round_half got=%0d/%0d exp=1/0", d, t); end
        get_out(d, t, w);
        total++; if (d !== 8'd0 || w !== 1) begin bad++; $display("FAIL round_below got=%0d gap=%0d exp=0 gap=1", d, w); end
    endtask

    task automatic test_fairness();
        logic [95:0] d;
        int c;
        do_reset();
        d = {$urandom, $urandom, $urandom};
        step();
        req_valid = 4'hF; req_data = d;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k < 8) begin
                total++;
                if (req_ready !== (4'b0001 << (k % 4))) begin
                    bad++;
                    $display("FAIL fair_grant k=%0d got=%b exp=%b", k, req_ready, 4'b0001 << (k % 4));
                end
            end
            if (k >= 3) begin
                c = (k - 3) % 4;
                total++;
                if (out_valid !== 1'b1 || out_tag !== c[1:0] || out_data !== rescale(d[c*24 +: 24], 8'd181)) begin
                    bad++;
                    $display("FAIL fair_result k=%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, out_valid, out_tag,
                             out_data, c, rescale(d[c*24 +: 24], 8'd181));
                end
            end
            step();
            if (k == 7) req_valid = 4'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d0;
        logic [1:0] t0;
        step();
        req_valid = 4'hF; req_data = {$urandom, $urandom, $urandom}; out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        @(negedge clk);
        d0 = out_data;
        t0 = out_tag;
        total++;
        if (req_ready !== 4'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_enter got=%b/%b exp=0000/1", req_ready, out_valid);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (req_ready !== 4'b0 || out_valid !== 1'b1 || out_data !== d0 || out_tag !== t0) begin
                bad++;
                $display("FAIL bp_hold k=%0d got=%b/%b/%0d/%0d exp=0000/1/%0d/%0d",
                         k, req_ready, out_valid, out_data, out_tag, d0, t0);
            end
        end
        step();
        out_ready = 1'b1;
        repeat (3) step();
        req_valid = 4'b0;
        repeat (5) step();
    endtask

    task automatic test_config();
        logic [7:0] d;
        logic [1:0] t;
        int w;
        do_reset();
        step();
        req_valid = 4'b0010; req_data = '0; req_data[47:24] = 24'h010000;
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_scale = 8'd2;
        @(negedge clk);
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL cfg_grant got=%b exp=0010", req_ready); end
        step();
        cfg_we = 1'b0;
        step();
        req_valid = 4'b0;
        get_out(d, t, w);
        total++;
        if (d !== rescale(24'h010000, 8'd181) || t !== 2'd1) begin
            bad++;
            $display("FAIL cfg_old_scale got=%0d/%0d exp=%0d/1", d, t, rescale(24'h010000, 8'd181));
        end
        get_out(d, t, w);
        total++;
        if (d !== 8'd2 || t !== 2'd1) begin bad++; $display("FAIL cfg_new_scale got=%0d/%0d exp=2/1", d, t); end
    endtask

    task automatic test_sat_and_flush();
        logic [7:0] d;
        logic [1:0] t;
        int w;
        logic [7:0] exp_sat;
`ifdef RESCALE_SAT_EN
        exp_sat = 8'd255;
`else
        exp_sat = 8'd80;
`endif
        step();
        req_valid = 4'b0100; req_data = '0; req_data[71:48] = 24'h100000;
        step();
        req_valid = 4'b0;
        get_out(d, t, w);
        total++; if (d !== exp_sat || t !== 2'd2) begin bad++; $display("FAIL sat_result got=%0d/%0d exp=%0d/2", d, t, exp_sat); end
        step();
        req_valid = 4'b1000; req_data[95:72] = 24'($urandom);
        repeat (5) step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b exp=1", out_valid); end
        #2;
        rstn = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", req_ready); end
        req_valid = 4'b0;
        step();
        step();
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_replay got=%b exp=0", out_valid); end
        end
    endtask

    task automatic test_random();
        logic [3:0] hsv;
        int n_hs;
        int n_out;
        n_hs = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            hsv = req_valid & req_ready;
            n_hs += $countones(hsv);
            if (out_valid === 1'b1 && out_ready === 1'b1) n_out++;
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) begin
                if (hsv[c] || !req_valid[c]) begin
                    req_valid[c] = 1'($urandom_range(0, 1));
                    req_data[c*24 +: 24] = 24'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_idx   = 2'($urandom);
            cfg_scale = 8'($urandom);
        end
        req_valid = 4'b0; out_ready = 1'b1; cfg_we = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) n_out++;
        end
        total++;
        if (n_out !== n_hs || n_hs == 0) begin
            bad++;
            $display("FAIL rand_count got=%0d results exp=%0d accepted (nonzero)", n_out, n_hs);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_fairness();
        test_backpressure();
        test_config();
        test_sat_and_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
